fifo_fwft_reader: RTL and testbench

- Read-side companion to our Synchronous_FIFO.
- Drives the FIFO read port (re_enb / data_out / empty) and converts its 1-cycle registered read latency into a first-word-fall-through valid/ready stream.
- Uses an internal 2-entry buffer (head + skid) so it sustains one word per clock with no bubbles.
- Sits between the FIFO and any downstream consumer, for example a serializer or packetizer.

---
 rtl/fifo_pkg.sv | 24 ++
 rtl/fwft_skid_buf.sv | 104 ++++++++++
 rtl/fifo_fwft_reader.sv | 96 +++++++++
 tb/tb_fifo_fwft_reader.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_pkg
//  Description : Shared constants and types for the Synchronous_FIFO family
//                and its first-word-fall-through read-side companion.
//                  c_FIFO_DATA_W - default word width
//                  c_FIFO_DEPTH  - FIFO depth shared with Synchronous_FIFO
//                  occ_state_t   - occupancy of the 2-entry head/skid buffer
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    localparam int c_FIFO_DATA_W = 8;
    localparam int c_FIFO_DEPTH  = 16;

    // Number of valid words held in the head/skid buffer.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL2 = 2'd2
    } occ_state_t;

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/fwft_skid_buf.sv
`default_nettype none
// ============================================================================
//  Module      : fwft_skid_buf
//  Description : Two-entry (head + skid) word store with FIFO ordering.
//                The head entry is what the consumer sees; the skid entry
//                absorbs a word landing while the head is held.
//  Ports       : clk        - clock, posedge
//                rst        - asynchronous reset, active low
//                capture    - cap_data is written this cycle
//                cap_data   - incoming word
//                pop        - head is consumed this cycle (only while valid)
//                head_data  - current head word
//                valid      - head holds a word
//                occupancy  - number of held words (0..2)
//  Revision    : 1.0 - initial release
// ============================================================================
module fwft_skid_buf
    import fifo_pkg::*;
#(
    parameter int DATA_W = c_FIFO_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              capture,
    input  logic [DATA_W-1:0] cap_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic              valid,
    output logic [1:0]        occupancy
);

    occ_state_t        r_state;
    occ_state_t        w_state_nxt;
    logic [DATA_W-1:0] r_head;
    logic [DATA_W-1:0] r_skid;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; capture together with pop leaves the count unchanged.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            EMPTY: begin
                if (capture) begin
                    w_state_nxt = ONE;
                end
            end
            ONE: begin
                if (capture && !pop) begin
                    w_state_nxt = FULL2;
                end else if (!capture && pop) begin
                    w_state_nxt = EMPTY;
                end
            end
            FULL2: begin
                if (pop && !capture) begin
                    w_state_nxt = ONE;
                end
            end
            default: begin
                w_state_nxt = EMPTY;
            end
        endcase
    end

    // Output logic
    always_comb begin
        valid     = (r_state != EMPTY);
        occupancy = r_state;
        head_data = r_head;
    end

    // Storage. A word always enters at the tail: the head when the head is
    // free (or leaving this cycle), the skid otherwise. Popping a full buffer
    // advances the skid into the head.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head <= '0;
            r_skid <= '0;
        end else begin
            if (pop && (r_state == FULL2)) begin
                r_head <= r_skid;
                if (capture) begin
                    r_skid <= cap_data;
                end
            end else if (capture) begin
                if ((r_state == EMPTY) || pop) begin
                    r_head <= cap_data;
                end else begin
                    r_skid <= cap_data;
                end
            end
        end
    end

endmodule : fwft_skid_buf
`default_nettype wire

// File: rtl/fifo_fwft_reader.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_fwft_reader
//  Description : Read-side companion to Synchronous_FIFO. Issues FIFO reads
//                and hides the 1-cycle registered read latency behind a
//                first-word-fall-through valid/ready stream, sustaining one
//                word per clock through a 2-entry head/skid buffer.
//  Ports       : clk           - clock, posedge
//                rst           - asynchronous reset, active low
//                fifo_empty    - FIFO empty flag
//                fifo_data_out - FIFO read data, valid the cycle after a read
//                fifo_re_enb   - FIFO read enable (pop)
//                m_data        - stream data (head entry)
//                m_valid       - m_data holds a valid word
//                m_ready       - consumer accepts the word this cycle
//                word_cnt      - saturating delivered-word count
//                                (only with FWFT_STATS_EN)
//  Build macro : FWFT_STATS_EN - adds the word_cnt port and counter
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_fwft_reader
    import fifo_pkg::*;
#(
    parameter int DATA_W = c_FIFO_DATA_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data_out,
    output logic              fifo_re_enb,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready
`ifdef FWFT_STATS_EN
    ,
    output logic [CNT_W-1:0]  word_cnt
`endif
);

    logic       r_inflight;
    logic       w_pop;
    logic [1:0] w_occ;
    logic [2:0] w_level;

    assign w_pop = m_valid && m_ready;

    // Words already owned by the reader once this cycle's pop is taken out.
    // A new read is only allowed while that leaves a free buffer slot, so the
    // word it returns next cycle always has somewhere to land.
    assign w_level     = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign fifo_re_enb = rst && !fifo_empty && (w_level < 3'd2);

    // A read issued this cycle delivers its word on fifo_data_out next cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= fifo_re_enb;
        end
    end

    fwft_skid_buf #(
        .DATA_W    (DATA_W)
    ) u_skid_buf (
        .clk       (clk),
        .rst       (rst),
        .capture   (r_inflight),
        .cap_data  (fifo_data_out),
        .pop       (w_pop),
        .head_data (m_data),
        .valid     (m_valid),
        .occupancy (w_occ)
    );

`ifdef FWFT_STATS_EN
    logic [CNT_W-1:0] r_word_cnt;

    // Saturating count of words accepted by the consumer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_word_cnt <= '0;
        end else if (w_pop && (r_word_cnt != {CNT_W{1'b1}})) begin
            r_word_cnt <= r_word_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign word_cnt = r_word_cnt;
`else
    // CNT_W has no consumer in this build.
    logic [CNT_W-1:0] w_unused_cnt_w;
    assign w_unused_cnt_w = '0;
`endif

endmodule : fifo_fwft_reader
`default_nettype wire

// File: tb/tb_fifo_fwft_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_fwft_reader
//  Description : Self-checking bench for fifo_fwft_reader. A behavioural
//                Synchronous_FIFO (queue with registered read data) feeds the
//                reader; every word written is pushed to an expected queue and
//                a negedge monitor pops and compares on each accepted word.
//  Build macro : FWFT_STATS_EN - also checks the saturating word_cnt
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_fwft_reader;
    import fifo_pkg::*;

    localparam int c_DW = 8;
    localparam int c_CW = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            fifo_empty;
    logic [c_DW-1:0] fifo_data_out;
    logic            fifo_re_enb;
    logic [c_DW-1:0] m_data;
    logic            m_valid;
    logic            m_ready = 1'b0;
`ifdef FWFT_STATS_EN
    logic [c_CW-1:0] word_cnt;
`endif

    int n_checks  = 0;
    int n_fail    = 0;
    int re_cnt    = 0;
    int delivered = 0;

    always #5 clk = ~clk;

    fifo_fwft_reader #(
        .DATA_W        (c_DW),
        .CNT_W         (c_CW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .fifo_empty    (fifo_empty),
        .fifo_data_out (fifo_data_out),
        .fifo_re_enb   (fifo_re_enb),
        .m_data        (m_data),
        .m_valid       (m_valid),
        .m_ready       (m_ready)
`ifdef FWFT_STATS_EN
        ,
        .word_cnt      (word_cnt)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural Synchronous_FIFO ----------------
    logic [c_DW-1:0] fq[$];
    int              fifo_count;
    logic            wr_en   = 1'b0;
    logic [c_DW-1:0] wr_data = '0;

    assign fifo_empty = (fifo_count == 0);

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            fq.delete();
            fifo_count    <= 0;
            fifo_data_out <= '0;
        end else begin
            int n;
            n = fifo_count;
            if (fifo_re_enb && (fq.size() > 0)) begin
                fifo_data_out <= fq.pop_front();
                n--;
            end
            if (wr_en && (fq.size() < c_FIFO_DEPTH)) begin
                fq.push_back(wr_data);
                n++;
            end
            fifo_count <= n;
        end
    end

    // ---------------- scoreboard monitor ----------------
    logic [c_DW-1:0] exp_q[$];
    logic            prev_stall = 1'b0;
    logic [c_DW-1:0] prev_data  = '0;

    always @(negedge clk) begin
        if (!rst) begin
            prev_stall = 1'b0;
        end else begin
            if (fifo_re_enb) re_cnt++;
            check("read_while_empty", {31'd0, fifo_re_enb && fifo_empty}, 32'd0);
            if (prev_stall) begin
                check("hold_valid", {31'd0, m_valid}, 32'd1);
                check("hold_data", {24'd0, m_data}, {24'd0, prev_data});
            end
            if (m_valid && m_ready) begin
                delivered++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_word: got 0x%0h, expected no word at %0t", m_data, $time);
                end else begin
                    check("stream_data", {24'd0, m_data}, {24'd0, exp_q.pop_front()});
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
        end
    end

    // ---------------- stimulus helpers (called at posedge + 1) ----------------
    task automatic write_word(input logic [c_DW-1:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        exp_q.push_back(d);
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int bound);
        for (int t = 0; t < bound && exp_q.size() != 0; t++) begin
            @(posedge clk); #1;
        end
        check(name, exp_q.size(), 32'd0);
    endtask

    initial begin
        int r0;
        int d0;
        int nw;

        // Reset state
        #3;
        check("rst_m_valid", {31'd0, m_valid}, 32'd0);
        check("rst_re_enb", {31'd0, fifo_re_enb}, 32'd0);
        check("rst_m_data", {24'd0, m_data}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Latency: single word into an empty FIFO
        m_ready = 1'b1;
        r0 = re_cnt;
        write_word(8'hA5);                 // now in cycle N: FIFO just went non-empty
        check("lat_empty_fell", {31'd0, fifo_empty}, 32'd0);
        check("lat_re_enb_N", {31'd0, fifo_re_enb}, 32'd1);
        @(posedge clk); #1;                // N+1
        check("lat_valid_N1", {31'd0, m_valid}, 32'd0);
        check("lat_re_enb_N1", {31'd0, fifo_re_enb}, 32'd0);
        @(posedge clk); #1;                // N+2
        check("lat_valid_N2", {31'd0, m_valid}, 32'd1);
        check("lat_data_N2", {24'd0, m_data}, 32'hA5);
        @(posedge clk); #1;                // N+3
        check("lat_valid_N3", {31'd0, m_valid}, 32'd0);
        check("lat_one_read", re_cnt - r0, 32'd1);

        // Streaming: 8 back-to-back words, no bubbles
        fork
            begin
                for (int i = 1; i <= 8; i++) write_word(i[7:0]);
            end
            begin
                int t;
                for (t = 0; t < 20 && !m_valid; t++) begin
                    @(posedge clk); #1;
                end
                check("stream_start", {31'd0, m_valid}, 32'd1);
                for (int i = 1; i < 8; i++) begin
                    @(posedge clk); #1;
                    check("stream_no_gap", {31'd0, m_valid}, 32'd1);
                end
                @(posedge clk); #1;
                check("stream_end", {31'd0, m_valid}, 32'd0);
            end
        join
        wait_drain("stream_drain", 10);

        // Backpressure: only two FIFO pops while the consumer stalls
        m_ready = 1'b0;
        r0 = re_cnt;
        for (int i = 1; i <= 8; i++) write_word(i[7:0]);
        repeat (10) begin
            @(posedge clk); #1;
        end
        check("bp_valid", {31'd0, m_valid}, 32'd1);
        check("bp_data", {24'd0, m_data}, 32'h01);
        check("bp_two_reads", re_cnt - r0, 32'd2);
        check("bp_fifo_level", fifo_count, 32'd6);
        m_ready = 1'b1;
        wait_drain("bp_drain", 40);
        @(posedge clk); #1;
        check("bp_idle", {31'd0, m_valid}, 32'd0);

        // Random writes and random consumer readiness
        d0 = delivered;
        nw = 0;
        for (int c = 0; c < 200; c++) begin
            m_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) != 0 && fifo_count < c_FIFO_DEPTH) begin
                wr_en   = 1'b1;
                wr_data = 8'($urandom);
                exp_q.push_back(wr_data);
                nw++;
            end else begin
                wr_en = 1'b0;
            end
            @(posedge clk); #1;
        end
        wr_en   = 1'b0;
        m_ready = 1'b1;
        wait_drain("rand_drain", 100);
        @(posedge clk); #1;
        check("rand_idle", {31'd0, m_valid}, 32'd0);
        check("rand_count", delivered - d0, nw);

        // Asynchronous reset with two words buffered
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) write_word(8'h30 + i[7:0]);
        repeat (4) begin
            @(posedge clk); #1;
        end
        check("prerst_valid", {31'd0, m_valid}, 32'd1);
        #2;
        rst = 1'b0;
        exp_q.delete();
        #1;
        check("arst_m_valid", {31'd0, m_valid}, 32'd0);
        check("arst_re_enb", {31'd0, fifo_re_enb}, 32'd0);
        check("arst_m_data", {24'd0, m_data}, 32'd0);
`ifdef FWFT_STATS_EN
        check("arst_word_cnt", {28'd0, word_cnt}, 32'd0);
`endif
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // 20 words after reset: counter saturates at 15 with a 4-bit width
        m_ready = 1'b1;
        d0 = delivered;
        for (int i = 0; i < 20; i++) write_word(8'h80 + i[7:0]);
        wait_drain("sat_drain", 20);
        @(posedge clk); #1;
        check("sat_delivered", delivered - d0, 32'd20);
`ifdef FWFT_STATS_EN
        check("word_cnt_sat", {28'd0, word_cnt}, 32'd15);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_fifo_fwft_reader
`default_nettype wire
